// File: rtl/i8243_host_if.sv
// rtl/i8243_host_if.sv - request/response and P2/PROG bus bundle for the 8243 host
interface i8243_host_if;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [1:0] req_port;
    logic [3:0] req_data;
    logic       rsp_valid;
    logic [3:0] rsp_data;
    logic       prog_n;
    logic [3:0] p2_out;
    logic       p2_oe;
    logic [3:0] p2_in;

    modport master (
        output req_valid, req_op, req_port, req_data, p2_in,
        input  req_ready, rsp_valid, rsp_data, prog_n, p2_out, p2_oe
    );

    modport slave (
        input  req_valid, req_op, req_port, req_data, p2_in,
        output req_ready, rsp_valid, rsp_data, prog_n, p2_out, p2_oe
    );
endinterface

// File: rtl/i8243_host.sv
// rtl/i8243_host.sv - 8243 port-expander host initiator (PROG strobe, P2 nibble bus)
module i8243_host #(
    parameter int ADDR_CYC = 2,
    parameter int LOW_CYC  = 4,
    parameter int HOLD_CYC = 1,
    parameter int REC_CYC  = 2
) (
    input  logic          clk,
    input  logic          rst,
    i8243_host_if.slave   bus
);
    localparam logic [1:0] OP_READ = 2'b00;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_STROBE,
        S_HOLD,
        S_RECOV
    } state_t;

    state_t     r_state, w_next_state;
    logic [3:0] r_cnt, w_next_cnt;
    logic [1:0] r_op, r_port, w_op, w_port;
    logic [3:0] r_data, w_data;
    logic       r_prog_n, w_prog_n;
    logic       r_p2_oe, w_p2_oe;
    logic [3:0] r_p2_out, w_p2_out;
    logic       r_rsp_valid, w_rsp_valid;
    logic [3:0] r_rsp_data, w_rsp_data;
    logic [3:0] r_sync1, r_sync2;
    logic       w_accept, w_capture;

    // Bus outputs are computed from the state being entered so every pin comes straight off a flop.
    always_comb begin
        w_accept     = bus.req_valid && (r_state == S_IDLE);
        w_op         = w_accept ? bus.req_op   : r_op;
        w_port       = w_accept ? bus.req_port : r_port;
        w_data       = w_accept ? bus.req_data : r_data;
        w_capture    = (r_state == S_STROBE) && (r_cnt == 4'd0);
        w_next_state = r_state;
        w_next_cnt   = (r_cnt != 4'd0) ? r_cnt - 4'd1 : 4'd0;

        case (r_state)
            S_IDLE: begin
                w_next_cnt = 4'd0;
                if (w_accept) begin
                    w_next_state = S_ADDR;
                    w_next_cnt   = 4'(ADDR_CYC - 1);
                end
            end
            S_ADDR: if (r_cnt == 4'd0) begin
                w_next_state = S_STROBE;
                w_next_cnt   = 4'(LOW_CYC - 1);
            end
            S_STROBE: if (r_cnt == 4'd0) begin
                w_next_state = S_HOLD;
                w_next_cnt   = 4'(HOLD_CYC - 1);
            end
            S_HOLD: if (r_cnt == 4'd0) begin
                w_next_state = S_RECOV;
                w_next_cnt   = 4'(REC_CYC - 1);
            end
            S_RECOV: if (r_cnt == 4'd0) begin
                w_next_state = S_IDLE;
                w_next_cnt   = 4'd0;
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_cnt   = 4'd0;
            end
        endcase

        w_prog_n = 1'b1;
        w_p2_oe  = 1'b0;
        w_p2_out = 4'd0;
        case (w_next_state)
            S_ADDR: begin
                w_p2_oe  = 1'b1;
                w_p2_out = {w_op, w_port};
            end
            S_STROBE: begin
                w_prog_n = 1'b0;
                w_p2_oe  = (w_op != OP_READ);
                w_p2_out = (w_op != OP_READ) ? w_data : 4'd0;
            end
            S_HOLD: begin
                w_p2_oe  = (w_op != OP_READ);
                w_p2_out = (w_op != OP_READ) ? w_data : 4'd0;
            end
            default: ;
        endcase

        w_rsp_valid = w_capture && (r_op == OP_READ);
        w_rsp_data  = w_rsp_valid ? r_sync2 : r_rsp_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_op        <= 2'd0;
            r_port      <= 2'd0;
            r_data      <= 4'd0;
            r_prog_n    <= 1'b1;
            r_p2_oe     <= 1'b0;
            r_p2_out    <= 4'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 4'd0;
            r_sync1     <= 4'd0;
            r_sync2     <= 4'd0;
        end else begin
            r_state     <= w_next_state;
            r_cnt       <= w_next_cnt;
            r_op        <= w_op;
            r_port      <= w_port;
            r_data      <= w_data;
            r_prog_n    <= w_prog_n;
            r_p2_oe     <= w_p2_oe;
            r_p2_out    <= w_p2_out;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_data  <= w_rsp_data;
            r_sync1     <= bus.p2_in;
            r_sync2     <= r_sync1;
        end
    end

    assign bus.req_ready = (r_state == S_IDLE);
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.prog_n    = r_prog_n;
    assign bus.p2_out    = r_p2_out;
    assign bus.p2_oe     = r_p2_oe;
endmodule
